// File: rtl/tjmono_ab_readout_scheduler.sv
// Two-sided (A/B) TJ-Monopix style matrix readout scheduler.
// Arbitrates between the A and B token requests, sequences the FREEZE/READ
// handshake of the granted side, strobes SAMPLE on the last READ-low cycle
// and keeps a saturating count of SAMPLE pulses.
module tjmono_ab_readout_scheduler #(
    parameter int unsigned FREEZE_SETUP = 2,
    parameter int unsigned READ_HIGH    = 2,
    parameter int unsigned READ_LOW     = 2,
    parameter int unsigned FREEZE_HOLD  = 3,
    parameter int unsigned MAX_READS    = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN_A,
    input  logic        EN_B,
    input  logic        TOK_A,
    input  logic        TOK_B,
    input  logic        STALL,
    input  logic        CLR_CNT,
    output logic        FREEZE_A,
    output logic        FREEZE_B,
    output logic        READ_A,
    output logic        READ_B,
    output logic        SEL_B,
    output logic        SAMPLE,
    output logic        BUSY,
    output logic [15:0] READ_CNT
);

    localparam int unsigned TMAX_0 = (FREEZE_SETUP > READ_HIGH) ? FREEZE_SETUP : READ_HIGH;
    localparam int unsigned TMAX_1 = (READ_LOW > FREEZE_HOLD) ? READ_LOW : FREEZE_HOLD;
    localparam int unsigned TMAX   = (TMAX_0 > TMAX_1) ? TMAX_0 : TMAX_1;
    localparam int unsigned CW     = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned RW     = $clog2(MAX_READS + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(FREEZE_SETUP - 1);
    localparam logic [CW-1:0] HIGH_LAST  = CW'(READ_HIGH - 1);
    localparam logic [CW-1:0] LOW_LAST   = CW'(READ_LOW - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(FREEZE_HOLD - 1);
    localparam logic [RW-1:0] READS_MAX  = RW'(MAX_READS);

    typedef enum logic [2:0] {
        IDLE,
        FRZ_SETUP,
        RD_HIGH,
        RD_LOW,
        FRZ_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [RW-1:0] reads_q, reads_d;
    logic [RW-1:0] reads_now;
    logic          side_q, side_d;      // granted side, 1 = B
    logic          last_b_q, last_b_d;  // side served by the previous grant
    logic          wait_q, wait_d;      // parked in RD_LOW after SAMPLE, waiting on STALL
    logic          rdy_q;               // one-cycle hold-off after reset release
    logic          req_a, req_b, req_g, grant_b;
    logic          sample_d;
    logic [15:0]   cnt_q, cnt_d;

    // State, phase timer, per-grant read count and arbitration bookkeeping
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            tcnt_q   <= '0;
            reads_q  <= '0;
            side_q   <= 1'b0;
            last_b_q <= 1'b1;
            wait_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            reads_q  <= reads_d;
            side_q   <= side_d;
            last_b_q <= last_b_d;
            wait_q   <= wait_d;
            rdy_q    <= 1'b1;
        end
    end

    // Next-state logic: arbitration, phase timing and read-loop exit decisions
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        reads_d   = reads_q;
        side_d    = side_q;
        last_b_d  = last_b_q;
        wait_d    = wait_q;
        grant_b   = side_q;
        reads_now = reads_q;
        req_a     = TOK_A & EN_A;
        req_b     = TOK_B & EN_B;
        req_g     = side_q ? req_b : req_a;
        case (state_q)
            IDLE: begin
                tcnt_d  = '0;
                reads_d = '0;
                wait_d  = 1'b0;
                if (rdy_q && (req_a || req_b)) begin
                    grant_b  = (req_a && req_b) ? ~last_b_q : req_b;
                    side_d   = grant_b;
                    last_b_d = grant_b;
                    state_d  = FRZ_SETUP;
                end
            end
            FRZ_SETUP: begin
                if (tcnt_q != SETUP_LAST) begin
                    tcnt_d = tcnt_q + 1'b1;
                end else if (!req_g) begin
                    state_d = FRZ_HOLD;
                    tcnt_d  = '0;
                end else if (!STALL) begin
                    state_d = RD_HIGH;
                    tcnt_d  = '0;
                end
            end
            RD_HIGH: begin
                if (tcnt_q != HIGH_LAST) begin
                    tcnt_d = tcnt_q + 1'b1;
                end else begin
                    state_d = RD_LOW;
                    tcnt_d  = '0;
                end
            end
            RD_LOW: begin
                if (!wait_q && (tcnt_q != LOW_LAST)) begin
                    tcnt_d = tcnt_q + 1'b1;
                end else begin
                    // The SAMPLE cycle itself still has to count its own read.
                    reads_now = wait_q ? reads_q : reads_q + 1'b1;
                    reads_d   = reads_now;
                    if (req_g && !STALL && (reads_now < READS_MAX)) begin
                        state_d = RD_HIGH;
                        tcnt_d  = '0;
                        wait_d  = 1'b0;
                    end else if (STALL) begin
                        wait_d = 1'b1;
                    end else begin
                        state_d = FRZ_HOLD;
                        tcnt_d  = '0;
                        wait_d  = 1'b0;
                    end
                end
            end
            FRZ_HOLD: begin
                if (tcnt_q != HOLD_LAST) begin
                    tcnt_d = tcnt_q + 1'b1;
                end else begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                    reads_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        sample_d = (state_d == RD_LOW) && (tcnt_d == LOW_LAST) && !wait_d;
    end

    // Registered matrix controls, decoded from the next state so they line up with the state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FREEZE_A <= 1'b0;
            FREEZE_B <= 1'b0;
            READ_A   <= 1'b0;
            READ_B   <= 1'b0;
            SEL_B    <= 1'b0;
            SAMPLE   <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            FREEZE_A <= (state_d != IDLE) && !side_d;
            FREEZE_B <= (state_d != IDLE) && side_d;
            READ_A   <= (state_d == RD_HIGH) && !side_d;
            READ_B   <= (state_d == RD_HIGH) && side_d;
            SEL_B    <= side_d;
            SAMPLE   <= sample_d;
            BUSY     <= (state_d != IDLE);
        end
    end

    // Saturating SAMPLE counter; a clear wins over a coincident SAMPLE
    always_comb begin
        cnt_d = cnt_q;
        if (CLR_CNT) begin
            cnt_d = '0;
        end else if (SAMPLE && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // READ_CNT register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign READ_CNT = cnt_q;

endmodule

// File: tb/tb_tjmono_ab_readout_scheduler.sv
// Directed bench for tjmono_ab_readout_scheduler: a per-cycle compare process
// checks handshake rules, SAMPLE placement and the READ_CNT model; the
// directed sequence checks grant-level results against hand-computed values.
module tb_tjmono_ab_readout_scheduler;

    localparam int unsigned FS = 2;
    localparam int unsigned RH = 2;
    localparam int unsigned RL = 2;
    localparam int unsigned FH = 3;
    localparam int unsigned MR = 64;

    logic        CLK = 1'b0;
    logic        RST_N, EN_A, EN_B, TOK_A, TOK_B, STALL, CLR_CNT;
    logic        FREEZE_A, FREEZE_B, READ_A, READ_B, SEL_B, SAMPLE, BUSY;
    logic [15:0] READ_CNT;

    tjmono_ab_readout_scheduler #(
        .FREEZE_SETUP(FS),
        .READ_HIGH   (RH),
        .READ_LOW    (RL),
        .FREEZE_HOLD (FH),
        .MAX_READS   (MR)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .EN_A    (EN_A),
        .EN_B    (EN_B),
        .TOK_A   (TOK_A),
        .TOK_B   (TOK_B),
        .STALL   (STALL),
        .CLR_CNT (CLR_CNT),
        .FREEZE_A(FREEZE_A),
        .FREEZE_B(FREEZE_B),
        .READ_A  (READ_A),
        .READ_B  (READ_B),
        .SEL_B   (SEL_B),
        .SAMPLE  (SAMPLE),
        .BUSY    (BUSY),
        .READ_CNT(READ_CNT)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference state kept by the compare process
    int          cyc = 0;
    logic [15:0] exp_cnt = '0;
    bit          cnt_chk_en = 1'b1;
    bit          clr_e, stall_e, fz, rd, exp_s;
    bit          prev_sample, prev_fa, prev_fb, prev_read;
    bit          in_grant, cur_side, first_read, stall_since, sample_pending;
    int          g_start, rise_cyc, fall_cyc, last_sample, g_samples;
    int          g_n = 0;
    int          g_side[16];
    int          g_len[16];
    int          g_samp[16];

    // Per-cycle compare against the handshake rules and the READ_CNT model
    always @(posedge CLK) begin
        clr_e   = CLR_CNT;
        stall_e = STALL;
        #1;
        cyc++;
        if (!RST_N) begin
            exp_cnt        = '0;
            prev_sample    = 1'b0;
            prev_fa        = 1'b0;
            prev_fb        = 1'b0;
            prev_read      = 1'b0;
            in_grant       = 1'b0;
            sample_pending = 1'b0;
        end else begin
            fz = FREEZE_A | FREEZE_B;
            rd = READ_A | READ_B;
            if (clr_e) exp_cnt = '0;
            else if (prev_sample && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (cnt_chk_en) check("read_cnt", 32'(READ_CNT), 32'(exp_cnt));
            check("both_freeze", 32'(FREEZE_A & FREEZE_B), 32'd0);
            check("read_without_freeze", 32'((READ_A & ~FREEZE_A) | (READ_B & ~FREEZE_B)), 32'd0);
            check("busy", 32'(BUSY), 32'(fz));
            check("idle_gap", 32'((prev_fa & FREEZE_B) | (prev_fb & FREEZE_A)), 32'd0);
            if (stall_e) stall_since = 1'b1;
            if (fz && !in_grant) begin
                in_grant       = 1'b1;
                cur_side       = FREEZE_B;
                g_start        = cyc;
                g_samples      = 0;
                first_read     = 1'b0;
                stall_since    = 1'b0;
                sample_pending = 1'b0;
            end
            if (fz) begin
                check("sel_b", 32'(SEL_B), 32'(cur_side));
                check("grant_side", 32'(FREEZE_B), 32'(cur_side));
            end
            if (rd && !prev_read) begin
                if (!first_read) check("setup_len", 32'(cyc - g_start), 32'(FS));
                first_read = 1'b1;
                rise_cyc   = cyc;
            end
            if (!rd && prev_read) begin
                check("read_high_len", 32'(cyc - rise_cyc), 32'(RH));
                sample_pending = 1'b1;
                fall_cyc       = cyc;
            end
            exp_s = sample_pending && (cyc - fall_cyc == int'(RL) - 1);
            check("sample", 32'(SAMPLE), 32'(exp_s));
            if (SAMPLE) begin
                if (g_samples > 0 && !stall_since)
                    check("sample_gap", 32'(cyc - last_sample), 32'(RH + RL));
                g_samples++;
                last_sample    = cyc;
                stall_since    = 1'b0;
                sample_pending = 1'b0;
            end
            if (!fz && in_grant) begin
                if (g_n < 16) begin
                    g_side[g_n] = int'(cur_side);
                    g_len[g_n]  = cyc - g_start;
                    g_samp[g_n] = g_samples;
                end
                g_n++;
                if (g_samples > 0 && !stall_since)
                    check("hold_len", 32'(cyc - last_sample), 32'(FH + 1));
                in_grant       = 1'b0;
                sample_pending = 1'b0;
            end
            prev_sample = SAMPLE;
            prev_fa     = FREEZE_A;
            prev_fb     = FREEZE_B;
            prev_read   = rd;
        end
    end

    task automatic wait_sample(input int budget, output int waited);
        bit seen = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            @(posedge CLK);
            #1;
            waited++;
            seen = SAMPLE;
        end
        check("wait_sample", 32'(seen), 32'd1);
    endtask

    task automatic wait_read(input bit side_b, input int budget);
        bit seen = 1'b0;
        int n    = 0;
        while (!seen && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
            seen = side_b ? READ_B : READ_A;
        end
        check("wait_read", 32'(seen), 32'd1);
    endtask

    task automatic wait_grants(input int target, input int budget);
        int n = 0;
        while (g_n < target && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("wait_grant", 32'(g_n >= target), 32'd1);
    endtask

    task automatic check_grant(input int idx, input int side, input int len, input int samp);
        check($sformatf("grant%0d_side", idx), 32'(g_side[idx]), 32'(side));
        check($sformatf("grant%0d_freeze_len", idx), 32'(g_len[idx]), 32'(len));
        check($sformatf("grant%0d_samples", idx), 32'(g_samp[idx]), 32'(samp));
    endtask

    // Hard stop in case something unforeseen blocks the sequence
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        int w;
        RST_N = 1'b0; EN_A = 1'b1; EN_B = 1'b0; TOK_A = 1'b1; TOK_B = 1'b0;
        STALL = 1'b0; CLR_CNT = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_freeze", 32'({FREEZE_A, FREEZE_B, READ_A, READ_B}), 32'd0);
        check("rst_sel_b", 32'(SEL_B), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_sample", 32'(SAMPLE), 32'd0);
        check("rst_read_cnt", 32'(READ_CNT), 32'd0);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;
        check("idle_after_first_edge", 32'(FREEZE_A | BUSY), 32'd0);
        @(posedge CLK); #1;
        check("leave_idle_second_edge", 32'(FREEZE_A), 32'd1);

        // Single grant of 3 reads on A
        wait_sample(50, w);
        wait_sample(50, w);
        @(posedge CLK); #1;
        TOK_A = 1'b0;
        wait_grants(1, 100);
        check_grant(0, 0, 17, 3);
        check("single_read_cnt", 32'(READ_CNT), 32'd3);

        // STALL held 10 cycles right after a SAMPLE
        TOK_A = 1'b1;
        wait_sample(50, w);
        STALL = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            check("stall_quiet", 32'(READ_A | SAMPLE), 32'd0);
        end
        STALL = 1'b0;
        wait_sample(50, w);
        check("stall_sample_delay", 32'(10 + w), 32'(RH + RL + 10));
        TOK_A = 1'b0;
        wait_grants(2, 100);
        check_grant(1, 0, 23, 2);
        check("stall_read_cnt", 32'(READ_CNT), 32'd5);

        // EN_B falls during the first RD_HIGH of a B grant
        TOK_B = 1'b1; EN_B = 1'b1;
        wait_read(1'b1, 50);
        EN_B = 1'b0;
        check("disable_sel_b", 32'(SEL_B), 32'd1);
        wait_grants(3, 100);
        check_grant(2, 1, 9, 1);
        TOK_B = 1'b0;
        check("disable_read_cnt", 32'(READ_CNT), 32'd6);

        // Saturation from a preloaded count
        @(negedge CLK);
        cnt_chk_en = 1'b0;
        force dut.cnt_q = 16'hFFFE;
        @(negedge CLK);
        release dut.cnt_q;
        exp_cnt    = 16'hFFFE;
        cnt_chk_en = 1'b1;
        TOK_A = 1'b1;
        wait_sample(50, w);
        @(posedge CLK); #1;
        check("sat_first_inc", 32'(READ_CNT), 32'hFFFF);
        wait_sample(50, w);
        wait_sample(50, w);
        TOK_A = 1'b0;
        wait_grants(4, 100);
        check_grant(3, 0, 17, 3);
        check("sat_hold", 32'(READ_CNT), 32'hFFFF);

        // CLR_CNT coincident with SAMPLE
        TOK_A = 1'b1;
        wait_sample(50, w);
        CLR_CNT = 1'b1;
        TOK_A   = 1'b0;
        @(posedge CLK); #1;
        CLR_CNT = 1'b0;
        check("clr_priority", 32'(READ_CNT), 32'd0);
        wait_grants(5, 100);

        // Asynchronous reset during RD_HIGH, then a tie after release
        TOK_A = 1'b1;
        wait_read(1'b0, 50);
        #3;
        RST_N = 1'b0;
        #1;
        check("async_rst_freeze_read", 32'({FREEZE_A, READ_A}), 32'd0);
        check("async_rst_busy", 32'(BUSY), 32'd0);
        TOK_B = 1'b1; EN_B = 1'b1;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_idle", 32'(FREEZE_A | FREEZE_B), 32'd0);
        @(posedge CLK); #1;
        check("post_rst_first_a", 32'({FREEZE_A, FREEZE_B}), 32'b10);

        // Tie held: A, B, A, each ending on MAX_READS
        for (int i = 0; i < 3 * int'(MR); i++) wait_sample(50, w);
        TOK_A = 1'b0; TOK_B = 1'b0;
        wait_grants(8, 100);
        check_grant(5, 0, 261, 64);
        check_grant(6, 1, 261, 64);
        check_grant(7, 0, 261, 64);

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tjmono_ab_readout_scheduler.md
TJMONO_AB_READOUT_SCHEDULER -- requirements
Module: tjmono_ab_readout_scheduler

Interface
REQ-001 SHALL have parameter FREEZE_SETUP, default 2, meaning cycles FREEZE is high before the first READ.
REQ-002 SHALL have parameter READ_HIGH, default 2, meaning cycles per READ high phase.
REQ-003 SHALL have parameter READ_LOW, default 2, meaning cycles per READ low phase.
REQ-004 SHALL have parameter FREEZE_HOLD, default 3, meaning cycles FREEZE stays high after the grant ends.
REQ-005 SHALL have parameter MAX_READS, default 64, meaning reads per grant before a forced switch of side.
REQ-006 SHALL have ports (name  direction  width  meaning):
- CLK  in  1  single clock, CLK40 domain.
- RST_N  in  1  reset; asynchronous, active-low.
- EN_A, EN_B  in  1 each  per-side enable.
- TOK_A, TOK_B  in  1 each  matrix token, already synchronous to CLK.
- STALL  in  1  downstream backpressure (FIFO near-full).
- CLR_CNT  in  1  synchronous clear of READ_CNT.
- FREEZE_A, FREEZE_B, READ_A, READ_B  out  1 each  matrix controls.
- SEL_B  out  1  datapath mux select (0 = A, 1 = B).
- SAMPLE  out  1  one-cycle strobe; the datapath captures the OUT bit.
- BUSY  out  1  high in every state except IDLE.
- READ_CNT  out  16  saturating count of SAMPLE pulses.

Function
REQ-007 SHALL implement the states IDLE, FRZ_SETUP, RD_HIGH, RD_LOW and FRZ_HOLD, each with a per-state cycle counter.
REQ-008 SHALL define the request of side X as TOK_X & EN_X.
REQ-009 SHALL arbitrate in IDLE as follows:
- Only one side requests: grant that side.
- Both sides request: grant the side opposite last_served.
- After the decision: set SEL_B, set last_served to the granted side, go to FRZ_SETUP.
REQ-010 SHALL remain in FRZ_SETUP for FREEZE_SETUP cycles, then go to RD_HIGH if the granted side is still requesting and STALL=0.
- Stays in FRZ_SETUP while STALL=1.
- Goes to FRZ_HOLD if the request has dropped.
REQ-011 SHALL drive READ of the granted side high for exactly READ_HIGH cycles in RD_HIGH, then go to RD_LOW.
REQ-012 SHALL assert SAMPLE for one cycle on the last RD_LOW cycle, increment the per-grant read count, then choose the next state as follows:
- Go to RD_HIGH if the request persists, STALL=0 and the per-grant count is below MAX_READS.
- Wait in RD_LOW with READ low and no further SAMPLE while STALL=1.
- Go to FRZ_HOLD otherwise.
REQ-013 SHALL hold FREEZE of the granted side high throughout FRZ_SETUP, RD_HIGH, RD_LOW and FRZ_HOLD.
REQ-014 SHALL keep FREEZE and READ of the non-granted side low at all times.
REQ-015 SHALL never have both FREEZE_A and FREEZE_B high in the same cycle.
REQ-016 SHALL return from FRZ_HOLD to IDLE after FREEZE_HOLD cycles and clear the per-grant count.
REQ-017 SHALL spend one IDLE cycle between grants, with both FREEZE outputs low.
REQ-018 SHALL complete the in-progress RD_HIGH/RD_LOW pair if EN of the granted side falls mid-grant; the count then takes the no-request exit to FRZ_HOLD.
REQ-019 SHALL make SEL_B change only in IDLE.
REQ-020 SHALL saturate READ_CNT at 16'hFFFF.
REQ-021 SHALL give CLR_CNT priority over a simultaneous increment, so READ_CNT becomes 0.
REQ-022 SHALL register all outputs.

Reset
REQ-023 SHALL, while RST_N=0, asynchronously force:
- state IDLE; all FREEZE/READ low; SAMPLE=0; BUSY=0; SEL_B=0.
- READ_CNT=0; last_served=B, so A wins the first tie.
REQ-024 SHALL, on reset asserted mid-grant, drop FREEZE/READ immediately, with no FRZ_HOLD phase.
REQ-025 SHALL leave IDLE no earlier than the second rising CLK edge after RST_N deasserts.

Verification
REQ-026 SHALL cover these directed scenarios:
- Single read: TOK_A high for 3 reads, EN_A=1, defaults -> FREEZE_A high 2+3×4+3 = 17 cycles, 3 SAMPLE pulses 4 cycles apart, READ_CNT=3.
- Tie: TOK_A=TOK_B=1 held -> grants alternate A, B, A; each grant ends after 64 SAMPLEs; never both FREEZE high.
- Stall: STALL=1 for 10 cycles inside RD_LOW -> SAMPLE is delayed 10 cycles; READ stays low; no extra SAMPLE.
- Mid-grant disable: EN_B falls during RD_HIGH -> that read completes with 1 SAMPLE, then FRZ_HOLD 3 cycles, then IDLE.
- Saturation and clear: preload to 16'hFFFE, 3 SAMPLEs -> READ_CNT=16'hFFFF; CLR_CNT coincident with SAMPLE -> 0.
- Async reset: RST_N low during RD_HIGH -> FREEZE/READ low in the same cycle without a clock edge; first grant after release goes to A.
